// File: rtl/memdp_resp_pkg.sv
// rtl/memdp_resp_pkg.sv - shared widths, FSM encodings and default depth for memdp_resp
package memdp_resp_pkg;

    localparam int SIZE_ADDR = 16;
    localparam int SIZE_DATA = 16;
    localparam int HBIT_ADDR = SIZE_ADDR - 1;
    localparam int HBIT_DATA = SIZE_DATA - 1;

    localparam int MEMDP_DEPTH_LOG2 = 8;

    typedef enum logic {
        MEMDP_S_CLEAR = 1'b0,
        MEMDP_S_RUN   = 1'b1
    } memdp_state_e;

endpackage

// File: rtl/memdp_resp_if.sv
// rtl/memdp_resp_if.sv - stage-4 memory-operation bus between the MO stage and the data memory
interface memdp_resp_if;
    import memdp_resp_pkg::*;

    logic [HBIT_ADDR:0] mem_addr  [0:1];
    logic [0:1]         mem_we;
    logic [HBIT_DATA:0] mem_wdata [0:1];
    logic [HBIT_DATA:0] mem_rdata [0:1];
    logic               ready;
    logic [0:1]         wbuf_valid;

    modport master (
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata, ready, wbuf_valid
    );

    modport slave (
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata, ready, wbuf_valid
    );

endinterface

// File: rtl/memdp_resp_bank.sv
// rtl/memdp_resp_bank.sv - one data bank: array, single-entry posted write buffer, read forwarding
module memdp_resp_bank
    import memdp_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = MEMDP_DEPTH_LOG2
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    input  logic                  i_clr,
    input  logic [DEPTH_LOG2-1:0] i_clr_idx,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [HBIT_DATA:0]    i_wdata,
    output logic [HBIT_DATA:0]    o_rdata,
    output logic                  o_wbuf_valid
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [HBIT_DATA:0]    r_mem [0:DEPTH-1];
    logic                  r_wbuf_valid;
    logic [DEPTH_LOG2-1:0] r_wbuf_idx;
    logic [HBIT_DATA:0]    r_wbuf_data;
    logic                  w_fwd_hit;

    // Capture a new posted write each strobe; an empty strobe just drains the buffer.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_wbuf_valid <= 1'b0;
            r_wbuf_idx   <= '0;
            r_wbuf_data  <= '0;
        end else begin
            r_wbuf_valid <= i_we;
            if (i_we) begin
                r_wbuf_idx  <= i_idx;
                r_wbuf_data <= i_wdata;
            end
        end
    end

    // Array write port: sweep clear, otherwise commit of the pending buffered write.
    always_ff @(posedge iw_clk) begin
        if (i_clr) begin
            r_mem[i_clr_idx] <= '0;
        end else if (r_wbuf_valid) begin
            r_mem[r_wbuf_idx] <= r_wbuf_data;
        end
    end

    assign w_fwd_hit    = r_wbuf_valid && (r_wbuf_idx == i_idx);
    assign o_rdata      = w_fwd_hit ? r_wbuf_data : r_mem[i_idx];
    assign o_wbuf_valid = r_wbuf_valid;

endmodule

// File: rtl/memdp_resp.sv
// rtl/memdp_resp.sv - dual-bank data memory responder with zero-sweep FSM and ready flag
module memdp_resp
    import memdp_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = MEMDP_DEPTH_LOG2,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic         iw_clk,
    input  logic         iw_rst_n,
    memdp_resp_if.slave  bus
);

    localparam memdp_state_e          S_AFTER_RESET = INIT_ZERO ? MEMDP_S_CLEAR : MEMDP_S_RUN;
    localparam logic                  READY_RESET   = INIT_ZERO ? 1'b0 : 1'b1;
    localparam logic [DEPTH_LOG2-1:0] CNT_LAST      = '1;
    localparam logic [DEPTH_LOG2-1:0] CNT_ONE       = 1;

    memdp_state_e          r_state;
    memdp_state_e          w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_cnt;
    logic [DEPTH_LOG2-1:0] w_cnt_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic                  w_clr;
    logic                  w_run;
    logic [2*(HBIT_ADDR-DEPTH_LOG2+1)-1:0] w_unused_addr_hi;

    // State, sweep counter and ready flag registers.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_state <= S_AFTER_RESET;
            r_cnt   <= '0;
            r_ready <= READY_RESET;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Sweep one index per cycle in CLEAR; the last index write hands over to RUN for good.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = r_ready;
        w_clr       = 1'b0;
        case (r_state)
            MEMDP_S_CLEAR: begin
                w_clr = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = MEMDP_S_RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            MEMDP_S_RUN: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_AFTER_RESET;
            end
        endcase
    end

    assign w_run     = (r_state == MEMDP_S_RUN);
    assign bus.ready = r_ready;

    // Address bits above the bank index have no meaning here.
    assign w_unused_addr_hi = {bus.mem_addr[0][HBIT_ADDR:DEPTH_LOG2],
                               bus.mem_addr[1][HBIT_ADDR:DEPTH_LOG2]};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [HBIT_DATA:0] w_rdata;
        logic               w_wbuf_valid;

        memdp_resp_bank #(
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_bank (
            .iw_clk       (iw_clk),
            .iw_rst_n     (iw_rst_n),
            .i_clr        (w_clr),
            .i_clr_idx    (r_cnt),
            .i_we         (bus.mem_we[b] & w_run),
            .i_idx        (bus.mem_addr[b][DEPTH_LOG2-1:0]),
            .i_wdata      (bus.mem_wdata[b]),
            .o_rdata      (w_rdata),
            .o_wbuf_valid (w_wbuf_valid)
        );

        assign bus.mem_rdata[b]  = w_run ? w_rdata : '0;
        assign bus.wbuf_valid[b] = w_wbuf_valid;
    end

endmodule

// File: tb/tb_memdp_resp.sv
// tb/tb_memdp_resp.sv - scoreboard bench for memdp_resp (INIT_ZERO=1 and INIT_ZERO=0 instances)
module tb_memdp_resp;
    import memdp_resp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_z;
    logic rst_nz;

    memdp_resp_if ifz ();
    memdp_resp_if ifn ();

    memdp_resp #(.DEPTH_LOG2(4), .INIT_ZERO(1'b1)) dut_z (
        .iw_clk   (clk),
        .iw_rst_n (rst_z),
        .bus      (ifz)
    );

    memdp_resp #(.DEPTH_LOG2(4), .INIT_ZERO(1'b0)) dut_n (
        .iw_clk   (clk),
        .iw_rst_n (rst_nz),
        .bus      (ifn)
    );

    // kinds: 0 z.ready 1 z.wbuf 2 z.rdata0 3 z.rdata1 4 n.ready 5 n.wbuf 6 n.rdata0 7 n.rdata1
    typedef struct {
        int                 kind;
        logic [HBIT_DATA:0] val;
        string              nm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t mon_e;
    logic [HBIT_DATA:0] mon_act;

    task automatic push_exp(input int kind, input logic [HBIT_DATA:0] val, input string nm);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.nm   = nm;
        sb_q.push_back(e);
    endtask

    function automatic logic [HBIT_DATA:0] actual(input int kind);
        case (kind)
            0:       return {15'd0, ifz.ready};
            1:       return {14'd0, ifz.wbuf_valid};
            2:       return ifz.mem_rdata[0];
            3:       return ifz.mem_rdata[1];
            4:       return {15'd0, ifn.ready};
            5:       return {14'd0, ifn.wbuf_valid};
            6:       return ifn.mem_rdata[0];
            7:       return ifn.mem_rdata[1];
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: drain every expectation posted for this cycle at the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = actual(mon_e.kind);
            n_cmp++;
            if (mon_act !== mon_e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", mon_e.nm, mon_act, mon_e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_z(input logic we0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic we1, input logic [15:0] a1, input logic [15:0] d1);
        ifz.mem_we       = {we0, we1};
        ifz.mem_addr[0]  = a0;
        ifz.mem_wdata[0] = d0;
        ifz.mem_addr[1]  = a1;
        ifz.mem_wdata[1] = d1;
    endtask

    task automatic drv_n(input logic we0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic we1, input logic [15:0] a1, input logic [15:0] d1);
        ifn.mem_we       = {we0, we1};
        ifn.mem_addr[0]  = a0;
        ifn.mem_wdata[0] = d0;
        ifn.mem_addr[1]  = a1;
        ifn.mem_wdata[1] = d1;
    endtask

    initial begin
        rst_z  = 1'b0;
        rst_nz = 1'b0;
        drv_z(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        drv_n(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();

        // Reset values of both instances
        push_exp(0, 16'h0, "z_rst_ready");
        push_exp(1, 16'h0, "z_rst_wbuf");
        push_exp(2, 16'h0, "z_rst_rdata0");
        push_exp(3, 16'h0, "z_rst_rdata1");
        push_exp(4, 16'h1, "n_rst_ready");
        push_exp(5, 16'h0, "n_rst_wbuf");

        // First sweep: ready rises exactly on the 16th edge
        rst_z = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            push_exp(0, (i == 16) ? 16'h1 : 16'h0, $sformatf("z_sweep1_ready_e%0d", i));
        end

        // Garbage into indices 12..15 of both banks, then read it back
        for (int a = 12; a <= 15; a++) begin
            drv_z(1'b1, 16'(a), 16'hDE00 | 16'(a), 1'b1, 16'(a), 16'hBE00 | 16'(a));
            tick();
        end
        for (int a = 12; a <= 15; a++) begin
            drv_z(1'b0, 16'(a), 16'h0, 1'b0, 16'(a), 16'h0);
            push_exp(2, 16'hDE00 | 16'(a), $sformatf("z_garbage0_a%0d", a));
            push_exp(3, 16'hBE00 | 16'(a), $sformatf("z_garbage1_a%0d", a));
            tick();
        end
        drv_z(1'b0, 16'hFF0D, 16'h0, 1'b0, 16'h120E, 16'h0);
        push_exp(2, 16'hDE0D, "z_addr_hi_ignored0");
        push_exp(3, 16'hBE0E, "z_addr_hi_ignored1");
        tick();

        // Reset, sweep to cnt=7 while reading a garbage index, reset again mid-sweep
        rst_z = 1'b0;
        drv_z(1'b1, 16'd15, 16'h5555, 1'b1, 16'd15, 16'h6666);
        tick();
        push_exp(0, 16'h0, "z_rst2_ready");
        rst_z = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            push_exp(0, 16'h0, $sformatf("z_part_ready_e%0d", i));
            push_exp(1, 16'h0, $sformatf("z_part_we_ignored_e%0d", i));
            push_exp(2, 16'h0, $sformatf("z_part_rdata0_e%0d", i));
        end
        rst_z = 1'b0;
        drv_z(1'b0, 16'd15, 16'h0, 1'b0, 16'd15, 16'h0);
        tick();
        rst_z = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            push_exp(0, (i == 16) ? 16'h1 : 16'h0, $sformatf("z_sweep2_ready_e%0d", i));
        end
        for (int a = 0; a < 16; a++) begin
            drv_z(1'b0, 16'(a), 16'h0, 1'b0, 16'(a), 16'h0);
            push_exp(2, 16'h0, $sformatf("z_zero0_a%0d", a));
            push_exp(3, 16'h0, $sformatf("z_zero1_a%0d", a));
            tick();
        end

        // Bank0 write addr 3 = A5: old, forwarded, then from array
        drv_z(1'b1, 16'd3, 16'h00A5, 1'b0, 16'd0, 16'h0);
        push_exp(2, 16'h0, "a5_same_cycle");
        push_exp(1, 16'h0, "a5_wbuf_before");
        tick();
        drv_z(1'b0, 16'd3, 16'h0, 1'b0, 16'd0, 16'h0);
        push_exp(2, 16'h00A5, "a5_forwarded");
        push_exp(1, 16'h2, "a5_wbuf_pending");
        tick();
        push_exp(2, 16'h00A5, "a5_from_array");
        push_exp(1, 16'h0, "a5_wbuf_drained");
        tick();

        // Bank1 back-to-back writes 5=11, 6=22
        drv_z(1'b0, 16'd0, 16'h0, 1'b1, 16'd5, 16'h0011);
        tick();
        drv_z(1'b0, 16'd0, 16'h0, 1'b1, 16'd6, 16'h0022);
        push_exp(3, 16'h0, "b2b_pre_write6");
        push_exp(1, 16'h1, "b2b_wbuf1");
        tick();
        drv_z(1'b0, 16'd0, 16'h0, 1'b0, 16'd5, 16'h0);
        push_exp(3, 16'h0011, "b2b_read5");
        push_exp(1, 16'h1, "b2b_wbuf1_still");
        tick();
        drv_z(1'b0, 16'd0, 16'h0, 1'b0, 16'd6, 16'h0);
        push_exp(3, 16'h0022, "b2b_read6");
        push_exp(1, 16'h0, "b2b_wbuf_drained");
        tick();

        // Bank0 write addr 2 while bank1 reads addr 2: no cross-bank effect
        drv_z(1'b1, 16'd2, 16'h0033, 1'b0, 16'd2, 16'h0);
        push_exp(2, 16'h0, "xb_rdata0_same");
        push_exp(3, 16'h0, "xb_rdata1_same");
        tick();
        drv_z(1'b0, 16'd2, 16'h0, 1'b0, 16'd2, 16'h0);
        push_exp(2, 16'h0033, "xb_rdata0_next");
        push_exp(3, 16'h0, "xb_rdata1_next");
        tick();
        push_exp(3, 16'h0, "xb_rdata1_later");
        tick();

        // INIT_ZERO=0: write in the first cycle after reset
        rst_nz = 1'b1;
        drv_n(1'b1, 16'd4, 16'h005A, 1'b0, 16'd0, 16'h0);
        push_exp(4, 16'h1, "n_ready_first");
        tick();
        drv_n(1'b0, 16'd4, 16'h0, 1'b0, 16'd0, 16'h0);
        push_exp(6, 16'h005A, "n_first_write_fwd");
        push_exp(5, 16'h2, "n_first_wbuf");
        push_exp(4, 16'h1, "n_ready_run");
        tick();
        push_exp(6, 16'h005A, "n_first_write_array");
        push_exp(5, 16'h0, "n_first_wbuf_drained");
        tick();

        // Reset with a write pending discards it
        drv_n(1'b1, 16'd7, 16'h0011, 1'b0, 16'd0, 16'h0);
        tick();
        drv_n(1'b1, 16'd7, 16'h0077, 1'b0, 16'd0, 16'h0);
        tick();
        rst_nz = 1'b0;
        drv_n(1'b0, 16'd7, 16'h0, 1'b0, 16'd0, 16'h0);
        #1;
        push_exp(5, 16'h0, "n_rst_wbuf_cleared");
        tick();
        rst_nz = 1'b1;
        tick();
        push_exp(6, 16'h0011, "n_pending_discarded");
        push_exp(5, 16'h0, "n_wbuf_after_rst");
        tick();

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
